des_decrypt_engine: RTL

//  Iterative DES decryptor, the inverse of the key-search datapath.
//  - Takes a 64-bit ciphertext block and a 64-bit key (for example the key latched by the cracker),

---
 rtl/des_pkg.sv | 149 ++++++++++++++
 rtl/des_decrypt_engine_round.sv | 27 ++
 rtl/des_decrypt_engine.sv | 128 ++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared DES definitions: FSM states, permutation and S-box tables, key-rotation
// schedules and the lookup helpers used by the decrypt engine and its round stage.
package des_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DN} state_t;

  // Permutation tables: 7-bit entries, first entry in the MSBs, unused tail zero-padded.
  // Entry n selects input bit n counted from the MSB (1-based), as in the DES tables.
  localparam logic [447:0] IP_T = {
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7};

  localparam logic [447:0] FP_T = {
    7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
    7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
    7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
    7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
    7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25};

  localparam logic [447:0] E_T = {
    7'd32, 7'd1,  7'd2,  7'd3,  7'd4,  7'd5,
    7'd4,  7'd5,  7'd6,  7'd7,  7'd8,  7'd9,
    7'd8,  7'd9,  7'd10, 7'd11, 7'd12, 7'd13,
    7'd12, 7'd13, 7'd14, 7'd15, 7'd16, 7'd17,
    7'd16, 7'd17, 7'd18, 7'd19, 7'd20, 7'd21,
    7'd20, 7'd21, 7'd22, 7'd23, 7'd24, 7'd25,
    7'd24, 7'd25, 7'd26, 7'd27, 7'd28, 7'd29,
    7'd28, 7'd29, 7'd30, 7'd31, 7'd32, 7'd1, 112'd0};

  localparam logic [447:0] P_T = {
    7'd16, 7'd7,  7'd20, 7'd21, 7'd29, 7'd12, 7'd28, 7'd17,
    7'd1,  7'd15, 7'd23, 7'd26, 7'd5,  7'd18, 7'd31, 7'd10,
    7'd2,  7'd8,  7'd24, 7'd14, 7'd32, 7'd27, 7'd3,  7'd9,
    7'd19, 7'd13, 7'd30, 7'd6,  7'd22, 7'd11, 7'd4,  7'd25, 224'd0};

  localparam logic [447:0] PC1_T = {
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4, 56'd0};

  localparam logic [447:0] PC2_T = {
    7'd14, 7'd17, 7'd11, 7'd24, 7'd1,  7'd5,
    7'd3,  7'd28, 7'd15, 7'd6,  7'd21, 7'd10,
    7'd23, 7'd19, 7'd12, 7'd4,  7'd26, 7'd8,
    7'd16, 7'd7,  7'd27, 7'd20, 7'd13, 7'd2,
    7'd41, 7'd52, 7'd31, 7'd37, 7'd47, 7'd55,
    7'd30, 7'd40, 7'd51, 7'd45, 7'd33, 7'd48,
    7'd44, 7'd49, 7'd39, 7'd56, 7'd34, 7'd53,
    7'd46, 7'd42, 7'd50, 7'd36, 7'd29, 7'd32, 112'd0};

  // S-boxes: 64 nibbles each, indexed by {row, col}, first nibble in the MSBs.
  localparam logic [255:0] SBOX_T [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Decrypt rotates right (K16 first), encrypt rotates left (K1 first).
  localparam logic [1:0] SHIFT_DEC [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                            2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  localparam logic [1:0] SHIFT_ENC [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                            2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Generic bit permutation; input is right-aligned in_w bits, output right-aligned out_w bits.
  function automatic logic [63:0] permute(input logic [63:0] din, input int in_w,
                                          input int out_w, input logic [447:0] tbl);
    logic [63:0] dout;
    int          n;
    dout = '0;
    for (int k = 0; k < out_w; k++) begin
      n = int'(tbl[447 - 7 * k -: 7]);
      dout[out_w - 1 - k] = din[in_w - n];
    end
    return dout;
  endfunction

  function automatic logic [3:0] sbox(input int unsigned n, input logic [5:0] x);
    logic [5:0] idx;
    idx = {x[5], x[0], x[4:1]};
    return SBOX_T[n][255 - 4 * int'(idx) -: 4];
  endfunction

  function automatic logic [63:0] ip(input logic [63:0] b);
    return permute(b, 64, 64, IP_T);
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] b);
    return permute(b, 64, 64, FP_T);
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] r);
    logic [63:0] t;
    t = permute({32'd0, r}, 32, 48, E_T);
    return t[47:0];
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] s);
    logic [63:0] t;
    t = permute({32'd0, s}, 32, 32, P_T);
    return t[31:0];
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [63:0] t;
    t = permute(k, 64, 56, PC1_T);
    return t[55:0];
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [63:0] t;
    t = permute({8'd0, cd}, 56, 48, PC2_T);
    return t[47:0];
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
    case (amt)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] amt);
    case (amt)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_decrypt_engine_round.sv
// One combinational DES Feistel round: L' = R, R' = L ^ P(S(E(R) ^ K)).
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] l_next,
  output logic [31:0] r_next
);

  logic [47:0] x;
  logic [31:0] s;

  // f-function: expand, key mix, substitute; the swap falls out of the port mapping
  always_comb begin
    x = e_exp(r) ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[31 - 4 * i -: 4] = sbox(i, x[47 - 6 * i -: 6]);
    end
  end

  assign l_next = r;
  assign r_next = l ^ p_perm(s);

endmodule

// File: rtl/des_decrypt_engine.sv
// Iterative DES decryptor: IP, 16 Feistel rounds with reversed subkeys, FP.
// ROUNDS_PER_CYCLE rounds are chained per RUN cycle (1, 2, 4, 8 or 16).
// Optional DES_ENC_MODE_EN adds a `decrypt` input selecting encryption when low.
module des_decrypt_engine
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef DES_ENC_MODE_EN
  input  logic        decrypt,
`endif
  input  logic [63:0] key,
  input  logic [63:0] ciphertext,
  output logic        ready,
  output logic        done,
  output logic [63:0] plaintext
);

  localparam int unsigned NR  = ROUNDS_PER_CYCLE;
  localparam logic [4:0]  RPC = 5'(ROUNDS_PER_CYCLE);

  state_t      state_q;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic [4:0]  rnd_q;
  logic [63:0] ip_blk;
  logic [55:0] pc1_key;
`ifdef DES_ENC_MODE_EN
  logic        mode_q;
`endif

  logic [NR:0][31:0] sl, sr;
  logic [NR:0][27:0] sc, sd;

  assign ip_blk  = ip(ciphertext);
  assign pc1_key = pc1(key);

  assign sl[0] = l_q;
  assign sr[0] = r_q;
  assign sc[0] = c_q;
  assign sd[0] = d_q;

  for (genvar j = 0; j < NR; j++) begin : g_stage
    logic [3:0]  ridx;
    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey;

    // rnd never exceeds 16 - NR while running, so the low nibble is the round index
    assign ridx = rnd_q[3:0] + 4'(j);
`ifdef DES_ENC_MODE_EN
    assign c_rot = mode_q ? rotr28(sc[j], SHIFT_DEC[ridx]) : rotl28(sc[j], SHIFT_ENC[ridx]);
    assign d_rot = mode_q ? rotr28(sd[j], SHIFT_DEC[ridx]) : rotl28(sd[j], SHIFT_ENC[ridx]);
`else
    assign c_rot = rotr28(sc[j], SHIFT_DEC[ridx]);
    assign d_rot = rotr28(sd[j], SHIFT_DEC[ridx]);
`endif
    assign subkey    = pc2({c_rot, d_rot});
    assign sc[j + 1] = c_rot;
    assign sd[j + 1] = d_rot;

    des_round u_round (
      .l      (sl[j]),
      .r      (sr[j]),
      .k      (subkey),
      .l_next (sl[j + 1]),
      .r_next (sr[j + 1])
    );
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      plaintext <= '0;
      rnd_q     <= '0;
      l_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
`ifdef DES_ENC_MODE_EN
      mode_q    <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE, DN: begin
          if (start) begin
            {l_q, r_q} <= ip_blk;
            {c_q, d_q} <= pc1_key;
            rnd_q      <= '0;
`ifdef DES_ENC_MODE_EN
            mode_q     <= decrypt;
`endif
            ready      <= 1'b0;
            state_q    <= RUN;
          end else begin
            ready   <= 1'b1;
            state_q <= IDLE;
          end
        end
        RUN: begin
          l_q   <= sl[NR];
          r_q   <= sr[NR];
          c_q   <= sc[NR];
          d_q   <= sd[NR];
          rnd_q <= rnd_q + RPC;
          if (rnd_q + RPC == 5'd16) begin
            // final swap undone before FP
            plaintext <= fp({sr[NR], sl[NR]});
            done      <= 1'b1;
            ready     <= 1'b1;
            state_q   <= DN;
          end
        end
        default: begin
          ready   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
